mem_access_unit: RTL

Sequential data-memory access stage for the RV32 core, directly upstream of the load-data extraction stage. It accepts one load or store request at a time and drives a word-addressed, req/ack data memory. For stores it generates big-endian byte enables and lane-replicated write data. For loads it captures the returned word and presents funct3, address and raw word to the extraction stage. Lane 0 (address offset 00) is bits [31:24].

---
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/mem_access_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request, data-memory and load-result signals of mem_access_unit.
// master: the access unit; slave: requester, memory and extraction stage.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [2:0]  ld_funct3;
   logic [31:0] ld_addr;
   logic [31:0] ld_mem_data;
   logic        done;
   logic        err;

   modport master (
      input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
      output req_ready,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata,
      output ld_funct3, ld_addr, ld_mem_data, done, err
   );

   modport slave (
      output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
      input  req_ready,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata,
      input  ld_funct3, ld_addr, ld_mem_data, done, err
   );
endinterface

// File: rtl/mem_access_unit.sv
// RV32 data-memory access stage: one load/store at a time over a req/ack bus.
// Ports: clk, rst_n (async, active low), bus (mem_access_unit_if.master).
// Big-endian lanes: offset 00 is bits [31:24], mem_be[3].
// Optional macro MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW give err.
module mem_access_unit #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input logic               clk,
   input logic               rst_n,
   mem_access_unit_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t state;
   state_t state_nx;

   logic        accept;
   logic        f3_ok;
   logic        misaligned;
   logic        legal;
   logic [3:0]  be_nx;
   logic [31:0] wdata_nx;
   logic        expire;
   logic        finish;

   logic [7:0]  cnt;
   logic        is_store_q;
   logic        err_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [2:0]  ld_funct3_q;
   logic [31:0] ld_addr_q;
   logic [31:0] ld_data_q;

   assign accept = bus.req_valid & (state == IDLE);
   assign expire = (cnt == 8'(ACK_TIMEOUT - 1));
   // Leaving ACCESS, either by ack (which wins over expiry) or timeout.
   assign finish = (state == ACCESS) & (bus.mem_ack | expire);

   always_comb begin
      f3_ok = 1'b0;
      if (bus.req_is_store) begin
         unique case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            default:                f3_ok = 1'b0;
         endcase
      end else begin
         unique case (bus.req_funct3)
            3'b000, 3'b001, 3'b010,
            3'b100, 3'b101:         f3_ok = 1'b1;
            default:                f3_ok = 1'b0;
         endcase
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      misaligned = 1'b0;
      unique case (bus.req_funct3[1:0])
         2'b01:   misaligned = bus.req_addr[0];
         2'b10:   misaligned = |bus.req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   assign legal = f3_ok & ~misaligned;

   // Store lanes; offending low bits are ignored when trapping is off.
   always_comb begin
      be_nx    = 4'b1111;
      wdata_nx = 32'h0;
      if (bus.req_is_store) begin
         unique case (bus.req_funct3[1:0])
            2'b00: begin
               be_nx    = 4'b1000 >> bus.req_addr[1:0];
               wdata_nx = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
               be_nx    = bus.req_addr[1] ? 4'b0011 : 4'b1100;
               wdata_nx = {2{bus.req_wdata[15:0]}};
            end
            default: begin
               be_nx    = 4'b1111;
               wdata_nx = bus.req_wdata;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (bus.req_valid) begin
               state_nx = legal ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            if (finish) begin
               state_nx = RESP;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= 8'h0;
         is_store_q  <= 1'b0;
         err_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'h0;
         be_q        <= 4'h0;
         wdata_q     <= 32'h0;
         ld_funct3_q <= 3'h0;
         ld_addr_q   <= 32'h0;
         ld_data_q   <= 32'h0;
      end else begin
         if (accept) begin
            ld_funct3_q <= bus.req_funct3;
            ld_addr_q   <= bus.req_addr;
            is_store_q  <= bus.req_is_store;
            err_q       <= ~legal;
            cnt         <= 8'h0;
            if (legal) begin
               addr_q  <= {bus.req_addr[31:2], 2'b00};
               we_q    <= bus.req_is_store;
               be_q    <= be_nx;
               wdata_q <= wdata_nx;
            end else if (!bus.req_is_store) begin
               ld_data_q <= 32'h0;
            end
         end
         if (state == ACCESS) begin
            if (bus.mem_ack) begin
               if (!is_store_q) begin
                  ld_data_q <= bus.mem_rdata;
               end
            end else if (expire) begin
               err_q <= 1'b1;
               if (!is_store_q) begin
                  ld_data_q <= 32'h0;
               end
            end else begin
               cnt <= cnt + 8'h1;
            end
         end
         // Bus fields return to zero once the access is over.
         if (finish) begin
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
         end
      end
   end

   assign bus.req_ready   = (state == IDLE);
   assign bus.mem_req     = (state == ACCESS);
   assign bus.mem_we      = we_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_be      = be_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.ld_funct3   = ld_funct3_q;
   assign bus.ld_addr     = ld_addr_q;
   assign bus.ld_mem_data = ld_data_q;
   assign bus.done        = (state == RESP);
   assign bus.err         = (state == RESP) & err_q;

endmodule
